// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO unit: op encoding, sequencer states, data width.
package hilo_pkg;

  localparam int unsigned HiloW = 32;

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpMthi  = 3'd3,
    OpMtlo  = 3'd4,
    OpMfhi  = 3'd5,
    OpMflo  = 3'd6
  } hilo_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StFix
  } hilo_state_t;

endpackage

// File: rtl/hilo_unsigned_fix.sv
// Turns the signed multiplier's high word into the unsigned high word for MULTU.
module hilo_unsigned_fix
  import hilo_pkg::*;
(
  input  logic [HiloW-1:0] in1_i,
  input  logic [HiloW-1:0] in2_i,
  input  logic [HiloW-1:0] mul_hi_i,
  input  logic             is_unsigned_i,
  output logic [HiloW-1:0] hi_o
);

  // A set top bit contributes 2^32 * other-operand that the signed product lost.
  always_comb begin
    hi_o = mul_hi_i;
    if (is_unsigned_i) begin
      hi_o = mul_hi_i + (in1_i[HiloW-1] ? in2_i : '0) + (in2_i[HiloW-1] ? in1_i : '0);
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner and multiply sequencer. Define HILO_BYPASS_EN to let MFHI/MFLO
// read the result being written in FIX instead of stalling one more cycle.
module hilo_unit
  import hilo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  hilo_op_t         op_code,
  input  logic [HiloW-1:0] op_rs,
  input  logic [HiloW-1:0] op_rt,
  output logic             stall,
  output logic [HiloW-1:0] mf_data,
  output logic             mul_start,
  output logic [HiloW-1:0] mul_in1,
  output logic [HiloW-1:0] mul_in2,
  input  logic [HiloW-1:0] mul_hi,
  input  logic [HiloW-1:0] mul_lo,
  input  logic             mul_busy
);

  hilo_state_t      state_q;
  logic [HiloW-1:0] hi_q, lo_q, in1_q, in2_q;
  logic             unsigned_q, seen_busy_q, mul_start_q;
  logic [HiloW-1:0] hi_fixed, hi_rd, lo_rd;
  logic             is_mf;

  hilo_unsigned_fix u_fix (
    .in1_i         (in1_q),
    .in2_i         (in2_q),
    .mul_hi_i      (mul_hi),
    .is_unsigned_i (unsigned_q),
    .hi_o          (hi_fixed)
  );

  assign mul_start = mul_start_q;
  assign mul_in1   = in1_q;
  assign mul_in2   = in2_q;
  assign is_mf     = (op_code == OpMfhi) || (op_code == OpMflo);

  always_comb begin
    stall = op_valid && (op_code != OpNone) && (state_q != StIdle);
    hi_rd = hi_q;
    lo_rd = lo_q;
`ifdef HILO_BYPASS_EN
    if (state_q == StFix) begin
      hi_rd = hi_fixed;
      lo_rd = mul_lo;
      if (is_mf) stall = 1'b0;
    end
`endif
  end

  always_comb begin
    mf_data = '0;
    if (op_valid && !stall) begin
      case (op_code)
        OpMfhi:  mf_data = hi_rd;
        OpMflo:  mf_data = lo_rd;
        default: mf_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      hi_q        <= '0;
      lo_q        <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      unsigned_q  <= 1'b0;
      seen_busy_q <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (op_valid) begin
            case (op_code)
              OpMthi: hi_q <= op_rs;
              OpMtlo: lo_q <= op_rs;
              OpMult, OpMultu: begin
                in1_q       <= op_rs;
                in2_q       <= op_rt;
                unsigned_q  <= (op_code == OpMultu);
                mul_start_q <= 1'b1;
                state_q     <= StLaunch;
              end
              default: ;
            endcase
          end
        end
        StLaunch: begin
          seen_busy_q <= 1'b0;
          state_q     <= StWait;
        end
        // Only a busy low after busy high means done; the multiplier may lag the start pulse.
        StWait: begin
          if (mul_busy) begin
            seen_busy_q <= 1'b1;
          end else if (seen_busy_q) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          hi_q    <= hi_fixed;
          lo_q    <= mul_lo;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
